vga_timing_param: RTL
=====================

# vga_timing_param

Parametrised raster timing generator: the next generation of the project's fixed XGA 1024x768 timing block. It produces the pixel/line counters, sync, blanking, display-enable and frame/line-start strobes for any mode set by parameters. It adds selectable sync polarity, a pixel clock-enable and a sticky frame-restart request. It sits at the head of the video pipeline and feeds every draw/overlay stage downstream.

## Interface
- CNT_W, 12, width of hcount/vcount
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch
- H_SYNC, 136, hsync width
- H_BP, 160, horizontal back porch (H_TOTAL = sum = 1344)
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch
- V_SYNC, 6, vsync width
- V_BP, 29, vertical back porch (V_TOTAL = sum = 806)
- H_SYNC_POL, 1, hsync active level
- V_SYNC_POL, 1, vsync active level

- clk_in  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ce  in  1  pixel enable; position advances only on clk_in edges with ce=1
- frame_restart  in  1  request to jump to (0,0); sticky until consumed
- hcount  out  CNT_W  pixel position in line
- vcount  out  CNT_W  line position in frame
- hsync  out  1  horizontal sync, level per H_SYNC_POL
- vsync  out  1  vertical sync, level per V_SYNC_POL
- hblnk  out  1  high when hcount >= H_ACTIVE
- vblnk  out  1  high when vcount >= V_ACTIVE
- de  out  1  high when !hblnk && !vblnk
- line_start  out  1  one-clk pulse when position becomes hcount=0
- frame_start  out  1  one-clk pulse when position becomes (0,0)

## Operation
- All outputs are registered. Each output is a function of the registered position and changes on the same edge as hcount/vcount. No output lags the counters.
- hsync active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. Otherwise it is at the inactive level.
- vsync active for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. It changes together with vcount at hcount=0.
- Advance on each ce=1 edge:
  - hcount increments, wrapping H_TOTAL-1 -> 0.
  - On the h-wrap, vcount increments, wrapping V_TOTAL-1 -> 0.
- ce=0: position, sync, blank and de hold. line_start/frame_start clear to 0, so each pulse lasts one clk even when ce is sparse.
- Restart latch:
  - frame_restart=1 sets an internal pending flag on any edge.
  - On the first edge with ce=1 and (pending or frame_restart), the next position is (0,0) regardless of current position. frame_start and line_start pulse, and pending clears.
  - A restart arriving at position (H_TOTAL-1, V_TOTAL-1) produces a single normal wrap, not a double event.
- Elaboration must fail if CNT_W cannot hold H_TOTAL-1 or V_TOTAL-1, or if any porch/sync parameter is 0.
- Reset state: hcount=0, vcount=0, hblnk=0, vblnk=0, de=1, hsync=!H_SYNC_POL, vsync=!V_SYNC_POL, line_start=0, frame_start=0, pending=0.
- Reset applies asynchronously at any point mid-frame.

## Timing
- Latency: one ce-qualified edge from position N to N+1. All outputs update on that same edge.
- The pulses are 1 after the edge that moves to hcount=0 (line_start) or to (0,0) (frame_start), and are cleared on the following clk edge.
- The first frame after reset emits no frame_start. The first frame_start occurs at the first wrap or restart.
- Frame period = H_TOTAL*V_TOTAL ce=1 edges, independent of the ce duty cycle.
- After rst_n deasserts, counting starts on the first ce=1 edge.

## Test plan
- Reset: hold rst_n=0 with ce=1 for 10 clks -> all outputs equal the reset state listed above. Release -> hcount steps 0,1,2 on successive edges.
- Default mode, ce=1, two full frames:
  - hsync=1 exactly for hcount 1048..1183.
  - vsync=1 exactly for vcount 771..776.
  - de count = 786432 per frame.
  - frame_start pulses spaced 1083264 clks apart.
- ce toggling 1,0 repeatedly:
  - frame_start spacing = 2166528 clks.
  - Each pulse is 1 clk wide.
  - Counters hold on ce=0 edges.
- Restart at (500,300) asserted for one clk while ce=0 for 3 clks, then ce=1 -> the next edge gives (0,0) with frame_start=1 and line_start=1; counting continues 1,2,3.
- Small mode (H 8/1/2/1, V 4/1/1/1, CNT_W=4, both polarities 0):
  - hsync=0 at hcount 9..10.
  - vsync=0 at vcount 5.
  - hcount wraps 11->0.
  - vcount wraps 6->0.
- Assert rst_n=0 asynchronously mid-line at (700,400), between clk edges -> outputs go to the reset state immediately, with no waiting for clk_in.

Source files
------------

// File: rtl/vga_timing_param_if.sv
// Raster timing bundle: pixel-enable and restart request in, position/sync/blank/strobes out.
// The generator uses "master"; downstream video stages use "slave".
interface vga_timing_param_if #(
    parameter int CNT_W = 12
);
    logic             ce;
    logic             frame_restart;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic             de;
    logic             line_start;
    logic             frame_start;

    modport master (
        input  ce, frame_restart,
        output hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start
    );

    modport slave (
        output ce, frame_restart,
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_param.sv
// Parametrised raster timing generator with sync polarity, pixel clock-enable and sticky restart.
// Every output is decoded from the next position, so all outputs move on the same edge as the counters.
module vga_timing_param #(
    parameter int CNT_W      = 12,
    parameter int H_ACTIVE   = 1024,
    parameter int H_FP       = 24,
    parameter int H_SYNC     = 136,
    parameter int H_BP       = 160,
    parameter int V_ACTIVE   = 768,
    parameter int V_FP       = 3,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 29,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    vga_timing_param_if.master   vga
);
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST   = H_ACTIVE + H_FP;
    localparam int HS_LAST    = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST   = V_ACTIVE + V_FP;
    localparam int VS_LAST    = VS_FIRST + V_SYNC - 1;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
        $error("vga_timing_param: porch, sync and active parameters must be non-zero");
    end
    if (longint'(H_TOTAL - 1) > CNT_MAX || longint'(V_TOTAL - 1) > CNT_MAX) begin : g_bad_width
        $error("vga_timing_param: CNT_W too narrow for H_TOTAL-1 or V_TOTAL-1");
    end

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             de_q, de_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             pending_q, pending_d;
    logic             restart_now;
    logic             h_last;
    logic             v_last;

    always_comb begin
        restart_now = vga.ce && (pending_q || vga.frame_restart);
        h_last      = (hcount_q == CNT_W'(H_TOTAL - 1));
        v_last      = (vcount_q == CNT_W'(V_TOTAL - 1));
        hcount_d    = hcount_q;
        vcount_d    = vcount_q;
        pending_d   = pending_q || vga.frame_restart;

        // A restart at the last pixel lands on (0,0) exactly like the natural wrap: one event only.
        if (restart_now) begin
            hcount_d  = '0;
            vcount_d  = '0;
            pending_d = 1'b0;
        end else if (vga.ce) begin
            if (h_last) begin
                hcount_d = '0;
                vcount_d = v_last ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end

        hblnk_d = (hcount_d >= CNT_W'(H_ACTIVE));
        vblnk_d = (vcount_d >= CNT_W'(V_ACTIVE));
        de_d    = !hblnk_d && !vblnk_d;
        hsync_d = (hcount_d >= CNT_W'(HS_FIRST) && hcount_d <= CNT_W'(HS_LAST)) ? H_SYNC_POL : !H_SYNC_POL;
        vsync_d = (vcount_d >= CNT_W'(VS_FIRST) && vcount_d <= CNT_W'(VS_LAST)) ? V_SYNC_POL : !V_SYNC_POL;

        // Strobes only fire on an advancing edge, so sparse ce still gives single-clk pulses.
        line_start_d  = vga.ce && (hcount_d == '0);
        frame_start_d = line_start_d && (vcount_d == '0);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= !H_SYNC_POL;
            vsync_q       <= !V_SYNC_POL;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            de_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            pending_q     <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            pending_q     <= pending_d;
        end
    end

    assign vga.hcount      = hcount_q;
    assign vga.vcount      = vcount_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.hblnk       = hblnk_q;
    assign vga.vblnk       = vblnk_q;
    assign vga.de          = de_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
endmodule
